// File: rtl/bus_fifo_arbiter_pkg.sv
// Shared constants and state encoding for the bus FIFO write-port arbiter.
// Other bus arbiters import the same definitions.
package bus_fifo_arbiter_pkg;

  localparam int BUS_DATA_W     = 32;
  localparam int BUS_FIFO_DEPTH = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/bus_fifo_arbiter_if.sv
// Requester-side and FIFO-side signals of the bus FIFO arbiter, bundled as one interface.
// The master modport is the environment (requesters and FIFO); the slave modport is the arbiter.
interface bus_fifo_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Handshake: requester i offers a word with req_valid[i]/req_data/req_last and holds them
  // stable until ack[i]. The word moves in the cycle where req_valid[i] & ack[i]. ack is the
  // ready; it may depend combinationally on req_valid, never the other way round.
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        ack;
  logic [N_REQ-1:0]        grant;

  logic                    valid_out_interface;
  logic [DATA_W-1:0]       out_interface;
  logic                    read_fifo_en;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;

  modport master (
    output req_valid, req_data, req_last, read_fifo_en, fifo_empty,
    input  ack, grant, valid_out_interface, out_interface, fifo_count
  );

  modport slave (
    input  req_valid, req_data, req_last, read_fifo_en, fifo_empty,
    output ack, grant, valid_out_interface, out_interface, fifo_count
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N_REQ.
// Shared with other bus arbiters; holds no state.
module rr_pick #(
  parameter int N_REQ = 4,
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] winner,
  output logic             any_req
);

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    // Scan farthest-first so the nearest requester after ptr is the last one written.
    for (int k = N_REQ; k >= 1; k--) begin
      int               idx;
      logic [PTR_W-1:0] idx_p;
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_p = PTR_W'(idx);
      if (req[idx_p]) begin
        winner  = idx_p;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_fifo_arbiter.sv
// Round-robin arbiter sharing the bus FIFO write port among N_REQ requesters, with a local
// credit counter so no word is ever offered to a full FIFO.
module bus_fifo_arbiter
  import bus_fifo_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = BUS_DATA_W,
  parameter int FIFO_DEPTH = BUS_FIFO_DEPTH,
  parameter int MAX_BURST  = 4
) (
  input  logic                clk,
  input  logic                reset,
  bus_fifo_arbiter_if.slave   bus,
  output state_e              dbg_state
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0]     BURST_LAST = 4'(MAX_BURST - 1);
  localparam logic [CNT_W:0] DEPTH_C    = (CNT_W + 1)'(FIFO_DEPTH);

  state_e              state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [3:0]          burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                vout_q, vout_d;
  logic [DATA_W-1:0]   dout_q, dout_d;

  logic [PTR_W-1:0]    winner;
  logic                any_req;
  logic                own_valid, own_last;
  logic [DATA_W-1:0]   own_data;
  logic                credit_ok, xfer, rd;
  logic [N_REQ-1:0]    ack;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // rr_ptr doubles as the owner index while BUSY.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rr_ptr_q == PTR_W'(i)) begin
        own_valid = bus.req_valid[i];
        own_last  = bus.req_last[i];
        own_data  = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rd = bus.read_fifo_en & ~bus.fifo_empty;
    // The word registered in vout_q lands in the FIFO at the next edge, so it already uses a slot.
    credit_ok = ({1'b0, count_q} + {{CNT_W{1'b0}}, vout_q}) < DEPTH_C;
    xfer      = (state_q == ST_BUSY) & own_valid & credit_ok;
    ack       = xfer ? grant_q : '0;

    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          rr_ptr_d        = winner;
          burst_cnt_d     = 4'd0;
          state_d         = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (xfer) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
          if (own_last || (burst_cnt_q == BURST_LAST)) begin
            grant_d = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    vout_d = xfer;
    dout_d = xfer ? own_data : dout_q;

    if (vout_q && !rd)                      count_d = count_q + 1'b1;
    else if (!vout_q && rd && count_q != '0) count_d = count_q - 1'b1;
    else                                     count_d = count_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= PTR_W'(N_REQ - 1);
      burst_cnt_q <= 4'd0;
      count_q     <= '0;
      vout_q      <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      count_q     <= count_d;
      vout_q      <= vout_d;
      dout_q      <= dout_d;
    end
  end

  assign bus.ack                 = ack;
  assign bus.grant               = grant_q;
  assign bus.valid_out_interface = vout_q;
  assign bus.out_interface       = dout_q;
  assign bus.fifo_count          = count_q;
  assign dbg_state               = state_q;

endmodule

// File: tb/tb_bus_fifo_arbiter.sv
// Directed bench for bus_fifo_arbiter: requester queues, a FIFO occupancy model and an
// in-order scoreboard of words expected at the FIFO write port.
module tb_bus_fifo_arbiter;
  import bus_fifo_arbiter_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b0;
  state_e dbg_state;

  always #5 clk = ~clk;

  bus_fifo_arbiter_if #(.N_REQ(4), .DATA_W(32), .FIFO_DEPTH(16)) bus ();

  bus_fifo_arbiter #(.N_REQ(4), .DATA_W(32), .FIFO_DEPTH(16), .MAX_BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] src_d[4][64];
  logic        src_l[4][64];
  int          hd[4];
  int          tl[4];
  logic [3:0]  ack_s = 4'b0;
  int          mcount = 0;
  int          wr_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic [31:0] d, input logic l);
    src_d[r][tl[r]] = d;
    src_l[r][tl[r]] = l;
    tl[r]++;
    exp_q.push_back(d);
  endtask

  task automatic wait_ack(input string tag);
    int c;
    for (c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ack != 4'b0) break;
    end
    chk(tag, 32'(c < 40), 32'd1);
  endtask

  task automatic wait_exp(input string tag);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (mcount == 0 && exp_q.size() == 0) break;
      bus.read_fifo_en = 1'b1;
    end
    bus.read_fifo_en = 1'b0;
    @(negedge clk);
    chk(tag, 32'(bus.fifo_count), 32'd0);
  endtask

  // Requester driver: pop a word after the edge that accepted it, then present the next.
  always @(negedge clk) ack_s = bus.ack;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (reset && ack_s[i] && hd[i] < tl[i]) hd[i]++;
      bus.req_valid[i]        = (hd[i] < tl[i]);
      bus.req_last[i]         = (hd[i] < tl[i]) ? src_l[i][hd[i]] : 1'b0;
      bus.req_data[i*32 +: 32] = (hd[i] < tl[i]) ? src_d[i][hd[i]] : 32'h0;
    end
    bus.fifo_empty = (mcount == 0);
  end

  // FIFO-side monitor: scoreboard, occupancy model, ack/grant invariants.
  always @(negedge clk) begin
    logic rd_m;
    logic [31:0] w;
    if (!reset) begin
      mcount = 0;
    end else begin
      chk("fifo_count_model", 32'(bus.fifo_count), 32'(mcount));
      chk("ack_within_grant", 32'(bus.ack & ~bus.grant), 32'd0);
      chk("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
      if (bus.valid_out_interface) begin
        wr_cnt++;
        chk("no_overflow", 32'(mcount < 16), 32'd1);
        chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          chk("write_data", bus.out_interface, w);
        end
      end
      rd_m = bus.read_fifo_en & ~bus.fifo_empty;
      if (bus.valid_out_interface && !rd_m)            mcount++;
      else if (!bus.valid_out_interface && rd_m && mcount > 0) mcount--;
    end
  end

  initial begin
    int          lens[3];
    int          nb;
    int          cur;
    int          wr0;
    int          c;
    logic [3:0]  prev_g;

    for (int i = 0; i < 4; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    bus.req_valid    = '0;
    bus.req_last     = '0;
    bus.req_data     = '0;
    bus.read_fifo_en = 1'b0;
    bus.fifo_empty   = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_vout", 32'(bus.valid_out_interface), 32'd0);
    chk("rst_data", bus.out_interface, 32'd0);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    #2 reset = 1'b1;

    // Round robin, one-word bursts
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) push(i, $urandom, 1'b1);
    for (c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.grant != 4'b0) break;
    end
    chk("rr_first_grant_seen", 32'(c < 20), 32'd1);
    for (int k = 0; k < 8; k++) begin
      chk("rr_grant", 32'(bus.grant), 32'(1 << (k % 4)));
      chk("rr_ack", 32'(bus.ack), 32'(1 << (k % 4)));
      @(negedge clk);
      chk("rr_bubble_grant", 32'(bus.grant), 32'd0);
      chk("rr_bubble_state", 32'(dbg_state), 32'(ST_IDLE));
      @(negedge clk);
    end
    wait_exp("rr_all_written");
    chk("rr_count8", 32'(bus.fifo_count), 32'd8);

    // Simultaneous write and read at count 8
    push(1, $urandom, 1'b1);
    wait_ack("sim_ack_seen");
    @(posedge clk); #1 bus.read_fifo_en = 1'b1;
    @(negedge clk);
    chk("sim_vout", 32'(bus.valid_out_interface), 32'd1);
    chk("sim_count_before", 32'(bus.fifo_count), 32'd8);
    @(posedge clk); #1 bus.read_fifo_en = 1'b0;
    @(negedge clk);
    chk("sim_count_after", 32'(bus.fifo_count), 32'd8);
    drain("sim_drain");

    // Read while empty at count 0
    @(posedge clk); #1 bus.read_fifo_en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("empty_read_count", 32'(bus.fifo_count), 32'd0);
    end
    @(posedge clk); #1 bus.read_fifo_en = 1'b0;

    // Burst cap: 10 words from requester 2, last flag only on the tenth so the bus is released
    @(negedge clk);
    for (int k = 0; k < 10; k++) push(2, $urandom, (k == 9));
    nb = 0;
    cur = 0;
    prev_g = 4'b0;
    for (c = 0; c < 80 && nb < 3; c++) begin
      @(negedge clk);
      if (bus.grant == 4'b0 && prev_g != 4'b0) begin
        chk("cap_owner", 32'(prev_g), 32'd4);
        lens[nb] = cur;
        nb++;
        cur = 0;
      end
      if (bus.ack != 4'b0) cur++;
      prev_g = bus.grant;
    end
    chk("cap_bursts", 32'(nb), 32'd3);
    chk("cap_len0", 32'(lens[0]), 32'd4);
    chk("cap_len1", 32'(lens[1]), 32'd4);
    chk("cap_len2", 32'(lens[2]), 32'd2);
    wait_exp("cap_all_written");
    drain("cap_drain");

    // Stall: owner drops req_valid mid-burst
    push(3, $urandom, 1'b0);
    wait_ack("stall_first_ack");
    chk("stall_owner", 32'(bus.grant), 32'd8);
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("stall_grant", 32'(bus.grant), 32'd8);
      chk("stall_ack", 32'(bus.ack), 32'd0);
      chk("stall_vout", 32'(bus.valid_out_interface), 32'd0);
      chk("stall_state", 32'(dbg_state), 32'(ST_BUSY));
    end
    push(3, $urandom, 1'b0);
    push(3, $urandom, 1'b1);
    wait_exp("stall_resume_written");
    chk("stall_release", 32'(bus.grant), 32'd0);
    drain("stall_drain");

    // Full FIFO: no reads, requester 0 streams 20 words
    wr0 = wr_cnt;
    for (int k = 0; k < 20; k++) push(0, $urandom, (k == 19));
    repeat (60) @(negedge clk);
    chk("full_writes16", 32'(wr_cnt - wr0), 32'd16);
    chk("full_count", 32'(bus.fifo_count), 32'd16);
    chk("full_ack", 32'(bus.ack), 32'd0);
    chk("full_grant", 32'(bus.grant), 32'd1);
    @(posedge clk); #1 bus.read_fifo_en = 1'b1;
    @(posedge clk); #1 bus.read_fifo_en = 1'b0;
    repeat (10) @(negedge clk);
    chk("full_writes17", 32'(wr_cnt - wr0), 32'd17);
    chk("full_count_again", 32'(bus.fifo_count), 32'd16);
    chk("full_ack_again", 32'(bus.ack), 32'd0);
    drain("full_drain");

    // Reset mid-burst with count 5
    for (int k = 0; k < 8; k++) push(0, $urandom, 1'b0);
    for (c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.fifo_count == 5'd5) break;
    end
    chk("mid_count5_seen", 32'(c < 40), 32'd1);
    chk("mid_state_busy", 32'(dbg_state), 32'(ST_BUSY));
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(bus.grant), 32'd0);
    chk("mid_rst_ack", 32'(bus.ack), 32'd0);
    chk("mid_rst_vout", 32'(bus.valid_out_interface), 32'd0);
    chk("mid_rst_count", 32'(bus.fifo_count), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    // After reset the pointer restarts, so requester 0 wins over requester 2
    @(negedge clk);
    push(0, $urandom, 1'b1);
    push(2, $urandom, 1'b1);
    wait_exp("post_rst_written");
    chk("post_rst_count", 32'(bus.fifo_count), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
